// File: rtl/branch_resolve_unit.sv
// Branch/jump resolution at the EX/MEM boundary.
// Computes the actual outcome and target of a branch, jal or jalr. It compares
// them against the prediction carried down the pipe and registers the MEM-stage
// update bus for instruction fetch. On a mispredict it raises PCSrc/flush for one
// cycle and then ignores FLUSH_DEPTH non-stall EX cycles, which hold wrong-path
// work. It also keeps saturating resolved-branch and mispredict counters.
//
// Ports:
//   clk, rst            clock (rising edge), synchronous active-low reset
//   stall               pipeline hold; EX inputs are re-presented afterwards
//   ex_*                EX-stage instruction class, operands and carried prediction
//   mem_pc, t_addr      PC and actual target of the last resolved instruction
//   mem_is_taken        actual direction of the last resolved instruction
//   mem_update          one-cycle strobe for the BHT/BTB update
//   PCSrc, flush        one-cycle mispredict redirect / pipeline kill
//   redirect_pc         correct next PC of the last resolved instruction
//   br_count, mp_count  saturating resolved-branch and mispredict counters
module branch_resolve_unit #(
  parameter int unsigned FLUSH_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        ex_valid,
  input  logic        ex_is_branch,
  input  logic        ex_is_jal,
  input  logic        ex_is_jalr,
  input  logic [2:0]  ex_funct3,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_rs1,
  input  logic [31:0] ex_rs2,
  input  logic [31:0] ex_imm,
  input  logic        ex_pred_taken,
  input  logic [31:0] ex_pred_target,
  output logic [31:0] mem_pc,
  output logic [31:0] t_addr,
  output logic        mem_is_taken,
  output logic        mem_update,
  output logic        PCSrc,
  output logic [31:0] redirect_pc,
  output logic        flush,
  output logic [31:0] br_count,
  output logic [31:0] mp_count
);

  typedef enum logic [0:0] {StIdle, StShadow} state_e;

  state_e      state_q, state_d;
  logic [2:0]  sc_q, sc_d;
  logic [31:0] mem_pc_q, t_addr_q, redirect_pc_q, br_count_q, mp_count_q;
  logic        taken_q, update_q, pcsrc_q;

  logic        br_legal, has_class, br_taken, taken, mispredict, capture;
  logic [31:0] target, next_redirect;

  // funct3 010/011 carry no branch condition and are dropped entirely.
  assign br_legal  = ex_is_branch && (ex_funct3[2:1] != 2'b01);
  assign has_class = ex_is_jalr || ex_is_jal || br_legal;

  always_comb begin
    br_taken = 1'b0;
    case (ex_funct3)
      3'b000:  br_taken = (ex_rs1 == ex_rs2);
      3'b001:  br_taken = (ex_rs1 != ex_rs2);
      3'b100:  br_taken = ($signed(ex_rs1) <  $signed(ex_rs2));
      3'b101:  br_taken = ($signed(ex_rs1) >= $signed(ex_rs2));
      3'b110:  br_taken = (ex_rs1 <  ex_rs2);
      3'b111:  br_taken = (ex_rs1 >= ex_rs2);
      default: br_taken = 1'b0;
    endcase
  end

  // jalr wins over jal and branch; jalr clears bit 0 of its target.
  assign target        = ex_is_jalr ? ((ex_rs1 + ex_imm) & 32'hFFFF_FFFE) : (ex_pc + ex_imm);
  assign taken         = (ex_is_jalr || ex_is_jal) ? 1'b1 : br_taken;
  assign mispredict    = (taken != ex_pred_taken) ||
                         (taken && ex_pred_taken && (ex_pred_target != target));
  assign next_redirect = taken ? target : (ex_pc + 32'd4);
  assign capture       = ex_valid && has_class && !stall && (state_q == StIdle);

  always_comb begin
    state_d = state_q;
    sc_d    = sc_q;
    case (state_q)
      StIdle: begin
        if (capture && mispredict) begin
          state_d = StShadow;
          sc_d    = 3'(FLUSH_DEPTH);
        end
      end
      StShadow: begin
        // The PCSrc cycle is the first shadow cycle; leave after the last one.
        if (!stall) begin
          if (sc_q == 3'd1) begin
            state_d = StIdle;
            sc_d    = 3'd0;
          end else begin
            sc_d = sc_q - 3'd1;
          end
        end
      end
      default: begin
        state_d = StIdle;
        sc_d    = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= StIdle;
      sc_q          <= 3'd0;
      mem_pc_q      <= 32'd0;
      t_addr_q      <= 32'd0;
      redirect_pc_q <= 32'd0;
      taken_q       <= 1'b0;
      update_q      <= 1'b0;
      pcsrc_q       <= 1'b0;
      br_count_q    <= 32'd0;
      mp_count_q    <= 32'd0;
    end else begin
      state_q  <= state_d;
      sc_q     <= sc_d;
      update_q <= capture;
      pcsrc_q  <= capture && mispredict;
      if (capture) begin
        mem_pc_q      <= ex_pc;
        t_addr_q      <= target;
        redirect_pc_q <= next_redirect;
        taken_q       <= taken;
        if (br_count_q != 32'hFFFF_FFFF) br_count_q <= br_count_q + 32'd1;
        if (mispredict && (mp_count_q != 32'hFFFF_FFFF)) mp_count_q <= mp_count_q + 32'd1;
      end
    end
  end

  assign mem_pc       = mem_pc_q;
  assign t_addr       = t_addr_q;
  assign mem_is_taken = taken_q;
  assign mem_update   = update_q;
  assign PCSrc        = pcsrc_q;
  assign flush        = pcsrc_q;
  assign redirect_pc  = redirect_pc_q;
  assign br_count     = br_count_q;
  assign mp_count     = mp_count_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        rst, stall, ex_valid, ex_is_branch, ex_is_jal, ex_is_jalr, ex_pred_taken;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_pc, ex_rs1, ex_rs2, ex_imm, ex_pred_target;
  logic [31:0] mem_pc, t_addr, redirect_pc, br_count, mp_count;
  logic        mem_is_taken, mem_update, PCSrc, flush;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        upd, pcsrc, taken;
    logic [31:0] taddr, pc, redir, br, mp;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  branch_resolve_unit #(.FLUSH_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .stall(stall), .ex_valid(ex_valid),
    .ex_is_branch(ex_is_branch), .ex_is_jal(ex_is_jal), .ex_is_jalr(ex_is_jalr),
    .ex_funct3(ex_funct3), .ex_pc(ex_pc), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_imm(ex_imm), .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
    .mem_pc(mem_pc), .t_addr(t_addr), .mem_is_taken(mem_is_taken),
    .mem_update(mem_update), .PCSrc(PCSrc), .redirect_pc(redirect_pc), .flush(flush),
    .br_count(br_count), .mp_count(mp_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle_in();
    ex_valid = 1'b0; ex_is_branch = 1'b0; ex_is_jal = 1'b0; ex_is_jalr = 1'b0;
    ex_funct3 = 3'b000; ex_pc = '0; ex_rs1 = '0; ex_rs2 = '0; ex_imm = '0;
    ex_pred_taken = 1'b0; ex_pred_target = '0;
  endtask

  task automatic drive(input logic br, input logic jal, input logic jalr, input logic [2:0] f3,
                       input logic [31:0] pc, input logic [31:0] rs1, input logic [31:0] rs2,
                       input logic [31:0] imm, input logic pt, input logic [31:0] ptgt);
    ex_valid = 1'b1; ex_is_branch = br; ex_is_jal = jal; ex_is_jalr = jalr;
    ex_funct3 = f3; ex_pc = pc; ex_rs1 = rs1; ex_rs2 = rs2; ex_imm = imm;
    ex_pred_taken = pt; ex_pred_target = ptgt;
  endtask

  task automatic expect_o(input logic upd, input logic pcsrc, input logic taken,
                          input logic [31:0] taddr, input logic [31:0] pc,
                          input logic [31:0] redir, input logic [31:0] br,
                          input logic [31:0] mp);
    exp_t e;
    e.upd = upd; e.pcsrc = pcsrc; e.taken = taken; e.taddr = taddr;
    e.pc = pc; e.redir = redir; e.br = br; e.mp = mp;
    sb.push_back(e);
  endtask

  // One clock: outputs for the inputs set before the edge are sampled 1 ns after it.
  task automatic step(input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk({tag, " scoreboard_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk({tag, " mem_update"},   {31'd0, mem_update},   {31'd0, e.upd});
      chk({tag, " PCSrc"},        {31'd0, PCSrc},        {31'd0, e.pcsrc});
      chk({tag, " flush"},        {31'd0, flush},        {31'd0, e.pcsrc});
      chk({tag, " mem_is_taken"}, {31'd0, mem_is_taken}, {31'd0, e.taken});
      chk({tag, " t_addr"},       t_addr,                e.taddr);
      chk({tag, " mem_pc"},       mem_pc,                e.pc);
      chk({tag, " redirect_pc"},  redirect_pc,           e.redir);
      chk({tag, " br_count"},     br_count,              e.br);
      chk({tag, " mp_count"},     mp_count,              e.mp);
    end
  endtask

  initial begin
    rst = 1'b0; stall = 1'b0; idle_in();
    expect_o(0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0);
    step("reset");
    rst = 1'b1;

    // BEQ taken, prediction correct
    drive(1, 0, 0, 3'b000, 32'h100, 32'd5, 32'd5, 32'h20, 1, 32'h120);
    expect_o(1, 0, 1, 32'h120, 32'h100, 32'h120, 1, 0);
    step("beq_hit");
    // BNE taken, back-to-back correct
    drive(1, 0, 0, 3'b001, 32'h104, 32'd1, 32'd2, 32'h8, 1, 32'h10C);
    expect_o(1, 0, 1, 32'h10C, 32'h104, 32'h10C, 2, 0);
    step("bne_hit");
    // BLTU: 0xFFFFFFFF < 1 is false unsigned; predicted not taken
    drive(1, 0, 0, 3'b110, 32'h10C, 32'hFFFF_FFFF, 32'd1, 32'h40, 0, 32'h0);
    expect_o(1, 0, 0, 32'h14C, 32'h10C, 32'h110, 3, 0);
    step("bltu_nt");
    // BLT signed 1 < -1 false, predicted taken -> mispredict
    drive(1, 0, 0, 3'b100, 32'h200, 32'd1, 32'hFFFF_FFFF, 32'h40, 1, 32'h240);
    expect_o(1, 1, 0, 32'h240, 32'h200, 32'h204, 4, 1);
    step("blt_mp");
    // Two shadow cycles ignore valid branches
    drive(1, 0, 0, 3'b000, 32'h300, 32'd7, 32'd7, 32'h4, 0, 32'h0);
    expect_o(0, 0, 0, 32'h240, 32'h200, 32'h204, 4, 1);
    step("shadow1");
    expect_o(0, 0, 0, 32'h240, 32'h200, 32'h204, 4, 1);
    step("shadow2");

    // JALR with wrong predicted target
    drive(0, 0, 1, 3'b000, 32'h400, 32'h1001, 32'h0, 32'h10, 1, 32'h1000);
    expect_o(1, 1, 1, 32'h1010, 32'h400, 32'h1010, 5, 2);
    step("jalr_mp");
    // Stalls inside SHADOW freeze sc: 4 cycles needed to clear depth 2
    drive(1, 0, 0, 3'b000, 32'h300, 32'd7, 32'd7, 32'h4, 0, 32'h0);
    stall = 1'b1;
    expect_o(0, 0, 1, 32'h1010, 32'h400, 32'h1010, 5, 2);
    step("sh_stall1");
    stall = 1'b0;
    expect_o(0, 0, 1, 32'h1010, 32'h400, 32'h1010, 5, 2);
    step("sh_run1");
    stall = 1'b1;
    expect_o(0, 0, 1, 32'h1010, 32'h400, 32'h1010, 5, 2);
    step("sh_stall2");
    stall = 1'b0;
    expect_o(0, 0, 1, 32'h1010, 32'h400, 32'h1010, 5, 2);
    step("sh_run2");

    // Stall in IDLE with a valid BNE, then release
    drive(1, 0, 0, 3'b001, 32'h500, 32'd3, 32'd4, 32'h10, 1, 32'h510);
    stall = 1'b1;
    expect_o(0, 0, 1, 32'h1010, 32'h400, 32'h1010, 5, 2);
    step("idle_stall");
    stall = 1'b0;
    expect_o(1, 0, 1, 32'h510, 32'h500, 32'h510, 6, 2);
    step("stall_release");

    // funct3 010 and no class: no update, no count
    drive(1, 0, 0, 3'b010, 32'h600, 32'd1, 32'd1, 32'h8, 1, 32'h608);
    expect_o(0, 0, 1, 32'h510, 32'h500, 32'h510, 6, 2);
    step("f3_010");
    drive(0, 0, 0, 3'b000, 32'h604, 32'd1, 32'd1, 32'h8, 1, 32'h60C);
    expect_o(0, 0, 1, 32'h510, 32'h500, 32'h510, 6, 2);
    step("no_class");

    // JAL backwards, predicted not taken -> mispredict, then reset mid-SHADOW
    drive(0, 1, 0, 3'b000, 32'h700, 32'h0, 32'h0, 32'hFFFF_FF00, 0, 32'h0);
    expect_o(1, 1, 1, 32'h600, 32'h700, 32'h600, 7, 3);
    step("jal_mp");
    drive(1, 0, 0, 3'b000, 32'h300, 32'd7, 32'd7, 32'h4, 0, 32'h0);
    expect_o(0, 0, 1, 32'h600, 32'h700, 32'h600, 7, 3);
    step("jal_shadow1");
    rst = 1'b0;
    expect_o(0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0);
    step("mid_reset");
    rst = 1'b1;
    drive(1, 0, 0, 3'b000, 32'h800, 32'd9, 32'd9, 32'h8, 1, 32'h808);
    expect_o(1, 0, 1, 32'h808, 32'h800, 32'h808, 1, 0);
    step("post_reset");

    // JAL target wraps around 2^32
    drive(0, 1, 0, 3'b000, 32'hFFFF_FFF0, 32'h0, 32'h0, 32'h20, 1, 32'h10);
    expect_o(1, 0, 1, 32'h10, 32'hFFFF_FFF0, 32'h10, 2, 0);
    step("jal_wrap");

    // Mispredict counter held at saturation
    force dut.mp_count_q = 32'hFFFF_FFFF;
    drive(1, 0, 0, 3'b000, 32'h900, 32'd1, 32'd2, 32'h10, 1, 32'h910);
    expect_o(1, 1, 0, 32'h910, 32'h900, 32'h904, 3, 32'hFFFF_FFFF);
    step("sat_mp1");
    release dut.mp_count_q;
    idle_in();
    expect_o(0, 0, 0, 32'h910, 32'h900, 32'h904, 3, 32'hFFFF_FFFF);
    step("sat_shadow1");
    expect_o(0, 0, 0, 32'h910, 32'h900, 32'h904, 3, 32'hFFFF_FFFF);
    step("sat_shadow2");
    drive(1, 0, 0, 3'b001, 32'hA00, 32'd1, 32'd1, 32'h10, 1, 32'hA10);
    expect_o(1, 1, 0, 32'hA10, 32'hA00, 32'hA04, 4, 32'hFFFF_FFFF);
    step("sat_mp2");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
